// File: rtl/lane_deskew_pkg.sv
// Shared types and constants for the lane deskew / destriping stage.
// Holds the FSM state encoding, the default alignment K-symbol and the
// per-lane symbol record stored in each lane buffer.
package lane_deskew_pkg;

    typedef enum logic {
        SEARCH  = 1'b0,
        ALIGNED = 1'b1
    } deskew_state_e;

    localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;

    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } symbol_t;

    // A symbol is the alignment marker only when it is a K-symbol with the COM value.
    function automatic logic is_com(input symbol_t s, input logic [7:0] com);
        return s.k && (s.data == com);
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane circular elastic buffer of DEPTH {k, data} entries.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   push, din    write din this cycle
//   pop          drop the head entry this cycle
//   flush        empty the buffer this cycle (takes priority over push/pop)
//   head         oldest stored symbol (valid when empty is low)
//   empty, full  occupancy flags
// DEPTH must be a power of two of at least 2 so the pointers wrap naturally.
module lane_fifo
    import lane_deskew_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  logic    flush,
    input  symbol_t din,
    output symbol_t head,
    output logic    empty,
    output logic    full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    symbol_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign head  = mem[rd_ptr];

    // A push into a full buffer is only accepted when the head leaves in the
    // same cycle; popping an empty buffer is ignored.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count; a flush behaves exactly like a reset.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lane_deskew.sv
// Receive-side lane deskew and destriping stage.
// Every lane feeds its own elastic buffer; the block discards symbols on each
// lane until all lane heads show COM together, then pops all lanes in lockstep
// and registers one symbol per lane as a single output word.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   in_valid     all lanes present a symbol this cycle
//   in_data      per-lane symbol, lane i in element i
//   in_k         per-lane K flag
//   out_valid    out_data/out_k hold an aligned word
//   out_data     destriped word, lane i in byte i
//   out_k        K flags matching out_data
//   aligned      high while in the ALIGNED state
//   deskew_err   one-cycle pulse on overflow or loss of alignment
module lane_deskew
    import lane_deskew_pkg::*;
#(
    parameter int         DATA_LANES = 4,
    parameter int         DEPTH      = 8,
    parameter logic [7:0] COM_SYM    = COM_SYM_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [DATA_LANES-1:0][7:0]  in_data,
    input  logic [DATA_LANES-1:0]       in_k,
    output logic                        out_valid,
    output logic [DATA_LANES-1:0][7:0]  out_data,
    output logic [DATA_LANES-1:0]       out_k,
    output logic                        aligned,
    output logic                        deskew_err
);

    deskew_state_e state;
    deskew_state_e next_state;

    symbol_t                       head [DATA_LANES];
    logic [DATA_LANES-1:0]         empty;
    logic [DATA_LANES-1:0]         full;
    logic [DATA_LANES-1:0]         head_com;
    logic [DATA_LANES-1:0][7:0]    head_data;
    logic [DATA_LANES-1:0]         head_k;
    logic [DATA_LANES-1:0]         pop;
    logic                          push;
    logic                          flush;
    logic                          load_word;
    logic                          raise_err;
    logic                          overflow;
    logic                          all_ne;
    logic                          all_com;
    logic                          any_com;

    // One buffer per lane; all lanes share push and flush so they stay in lockstep.
    for (genvar g = 0; g < DATA_LANES; g++) begin : g_lane
        symbol_t lane_in;

        assign lane_in      = {in_k[g], in_data[g]};
        assign head_com[g]  = is_com(head[g], COM_SYM);
        assign head_data[g] = head[g].data;
        assign head_k[g]    = head[g].k;

        lane_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push),
            .pop   (pop[g]),
            .flush (flush),
            .din   (lane_in),
            .head  (head[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    // Only non-empty lanes count towards the COM tests; an empty lane's head is stale.
    assign all_ne  = &(~empty);
    assign all_com = &(head_com & ~empty);
    assign any_com = |(head_com & ~empty);

    // Next-state, per-lane pop and flush decisions. Overflow is evaluated last
    // because it overrides whatever the alignment logic decided this cycle.
    always_comb begin
        next_state = state;
        pop        = '0;
        flush      = 1'b0;
        load_word  = 1'b0;
        raise_err  = 1'b0;

        case (state)
            SEARCH: begin
                if (all_com) begin
                    pop        = '1;
                    load_word  = 1'b1;
                    next_state = ALIGNED;
                end else begin
                    pop = ~empty & ~head_com;
                end
            end
            ALIGNED: begin
                if (all_ne) begin
                    pop = '1;
                    if (any_com && !all_com) begin
                        raise_err  = 1'b1;
                        flush      = 1'b1;
                        next_state = SEARCH;
                    end else begin
                        load_word = 1'b1;
                    end
                end
            end
            default: begin
                next_state = SEARCH;
            end
        endcase

        overflow = in_valid && |(full & ~pop);
        if (overflow) begin
            raise_err  = 1'b1;
            flush      = 1'b1;
            load_word  = 1'b0;
            next_state = SEARCH;
        end

        push = in_valid && !flush;
    end

    // State and output registers; out_data/out_k hold their last word between loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SEARCH;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_k      <= '0;
            aligned    <= 1'b0;
            deskew_err <= 1'b0;
        end else begin
            state      <= next_state;
            out_valid  <= load_word;
            deskew_err <= raise_err;
            aligned    <= (next_state == ALIGNED);
            if (load_word) begin
                out_data <= head_data;
                out_k    <= head_k;
            end
        end
    end

endmodule

// File: tb/tb_lane_deskew.sv
// Self-checking bench for lane_deskew (4 lanes, DEPTH 8).
// A table of hand-derived vectors covers the zero-skew stream and a misalignment;
// skewed, gapped and randomised streams are checked against a queue-based model.
module tb_lane_deskew;
    import lane_deskew_pkg::*;

    localparam int NL = 4;
    localparam int DP = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic [NL-1:0][7:0]   in_data;
    logic [NL-1:0]        in_k;
    logic                 out_valid;
    logic [NL-1:0][7:0]   out_data;
    logic [NL-1:0]        out_k;
    logic                 aligned;
    logic                 deskew_err;

    lane_deskew #(
        .DATA_LANES (NL),
        .DEPTH      (DP),
        .COM_SYM    (8'hBC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_k       (in_k),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_k      (out_k),
        .aligned    (aligned),
        .deskew_err (deskew_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_count  = 0;
    int fail_count = 0;

    // Scenario trackers, updated from the DUT after every cycle.
    int err_seen;
    int err_consec;
    int aligned_seen;
    bit prev_err;

    // Behavioural model: one queue per lane plus the visible output state.
    symbol_t     mq [NL][$];
    bit          m_aligned;
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_k;
    logic        m_err;

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [31:0] data;
        logic [3:0]  k;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_k;
        logic        e_aligned;
        logic        e_err;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d, input logic [3:0] k,
                                input logic ev, input logic [31:0] ed, input logic [3:0] ek,
                                input logic ea, input logic ee);
        vec_t t;
        t.rst_n = r; t.valid = v; t.data = d; t.k = k;
        t.e_valid = ev; t.e_data = ed; t.e_k = ek; t.e_aligned = ea; t.e_err = ee;
        return t;
    endfunction

    function automatic logic [31:0] rep(input logic [7:0] b);
        return {b, b, b, b};
    endfunction

    function automatic bit sym_is_com(input symbol_t s);
        return (s.k == 1'b1) && (s.data == 8'hBC);
    endfunction

    function automatic logic [38:0] dut_word();
        return {out_valid, out_data, out_k, aligned, deskew_err};
    endfunction

    function automatic logic [38:0] model_word();
        return {m_valid, m_data, m_k, m_aligned, m_err};
    endfunction

    // Advance the model by one clock using the rules of the deskew stage.
    task automatic model_cycle(input logic r, input logic v, input logic [31:0] d, input logic [3:0] k);
        int          n_ne;
        int          n_com;
        bit          pop_l [NL];
        bit          load;
        bit          drop;
        bit          ovf;
        logic [31:0] word_d;
        logic [3:0]  word_k;
        symbol_t     s;
        if (!r) begin
            for (int l = 0; l < NL; l++) mq[l].delete();
            m_aligned = 0; m_valid = 0; m_data = '0; m_k = '0; m_err = 0;
            return;
        end
        n_ne = 0; n_com = 0; load = 0; drop = 0; ovf = 0;
        word_d = '0; word_k = '0;
        for (int l = 0; l < NL; l++) begin
            pop_l[l] = 0;
            if (mq[l].size() > 0) begin
                n_ne++;
                if (sym_is_com(mq[l][0])) n_com++;
            end
        end
        if (!m_aligned) begin
            if (n_com == NL) begin
                load = 1;
                for (int l = 0; l < NL; l++) pop_l[l] = 1;
            end else begin
                for (int l = 0; l < NL; l++)
                    pop_l[l] = (mq[l].size() > 0) && !sym_is_com(mq[l][0]);
            end
        end else if (n_ne == NL) begin
            for (int l = 0; l < NL; l++) pop_l[l] = 1;
            if (n_com > 0 && n_com < NL) drop = 1;
            else load = 1;
        end
        if (v) begin
            for (int l = 0; l < NL; l++)
                if (mq[l].size() == DP && !pop_l[l]) ovf = 1;
        end
        m_valid = 0;
        m_err   = 0;
        if (ovf || drop) begin
            for (int l = 0; l < NL; l++) mq[l].delete();
            m_err     = 1;
            m_aligned = 0;
        end else begin
            if (load) begin
                for (int l = 0; l < NL; l++) begin
                    word_d[8*l +: 8] = mq[l][0].data;
                    word_k[l]        = mq[l][0].k;
                end
                m_data    = word_d;
                m_k       = word_k;
                m_valid   = 1;
                m_aligned = 1;
            end
            for (int l = 0; l < NL; l++)
                if (pop_l[l]) void'(mq[l].pop_front());
            if (v) begin
                for (int l = 0; l < NL; l++) begin
                    s.k    = k[l];
                    s.data = d[8*l +: 8];
                    mq[l].push_back(s);
                end
            end
        end
    endtask

    // Drive one cycle of inputs, step the model, and land #1 after the edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d, input logic [3:0] k);
        rst_n    = r;
        in_valid = v;
        in_data  = d;
        in_k     = k;
        model_cycle(r, v, d, k);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [38:0] act, input logic [38:0] exp);
        vec_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got {v,data,k,al,err}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic track();
        if (deskew_err === 1'b1) begin
            err_seen++;
            if (prev_err) err_consec++;
        end
        prev_err = (deskew_err === 1'b1);
        if (aligned === 1'b1) aligned_seen = 1;
    endtask

    task automatic clear_track();
        err_seen = 0; err_consec = 0; aligned_seen = 0; prev_err = 0;
    endtask

    task automatic step(input string name, input logic r, input logic v, input logic [31:0] d, input logic [3:0] k);
        applyStimulus(r, v, d, k);
        checkOutput(name, dut_word(), model_word());
        track();
    endtask

    // Stream with COM every 16 symbols; lane l lags the reference by sk[l] writes.
    task automatic run_skewed(input string name, input int sk0, input int sk1, input int sk2, input int sk3,
                              input int nwrites, input int gap_pct, input int inject_at, input logic [7:0] base);
        int          sk [NL];
        int          w;
        int          cycles;
        int          idx;
        logic [31:0] d;
        logic [3:0]  k;
        sk[0] = sk0; sk[1] = sk1; sk[2] = sk2; sk[3] = sk3;
        w = 0;
        cycles = 0;
        while (w < nwrites && cycles < 2000) begin
            cycles++;
            if ($urandom_range(99) < gap_pct) begin
                step(name, 1'b1, 1'b0, '0, '0);
            end else begin
                for (int l = 0; l < NL; l++) begin
                    idx = w - sk[l];
                    if (idx < 0) begin
                        d[8*l +: 8] = 8'h00; k[l] = 1'b0;
                    end else if (idx % 16 == 0) begin
                        d[8*l +: 8] = 8'hBC; k[l] = 1'b1;
                    end else begin
                        d[8*l +: 8] = 8'(idx) + base; k[l] = 1'b0;
                    end
                end
                if (w == inject_at) begin
                    d[7:0] = 8'hBC; k[0] = 1'b1;
                end
                step(name, 1'b1, 1'b1, d, k);
                w++;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_k     = '0;
        clear_track();

        // Zero-skew stream, then a partial-COM word to force loss of alignment.
        tbl.push_back(mk(0, 0, 32'h0,      4'h0, 0, 32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(1, 1, rep(8'hBC), 4'hF, 0, 32'h0,        4'h0, 0, 0));
        for (int i = 1; i <= 7; i++) begin
            if (i == 1)
                tbl.push_back(mk(1, 1, rep(8'(i)), 4'h0, 1, rep(8'hBC), 4'hF, 1, 0));
            else
                tbl.push_back(mk(1, 1, rep(8'(i)), 4'h0, 1, rep(8'(i - 1)), 4'h0, 1, 0));
        end
        tbl.push_back(mk(1, 0, 32'h0,        4'h0, 1, rep(8'h07), 4'h0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, rep(8'h07), 4'h0, 1, 0));
        tbl.push_back(mk(1, 1, rep(8'hBC),   4'hF, 0, rep(8'h07), 4'h0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h5555BCBC, 4'h3, 1, rep(8'hBC), 4'hF, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, rep(8'hBC), 4'hF, 0, 1));
        tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, rep(8'hBC), 4'hF, 0, 0));
        tbl.push_back(mk(1, 1, rep(8'hBC),   4'hF, 0, rep(8'hBC), 4'hF, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,        4'h0, 1, rep(8'hBC), 4'hF, 1, 0));

        $display("[TB] table vectors");
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst_n, tbl[i].valid, tbl[i].data, tbl[i].k);
            checkOutput($sformatf("table[%0d]", i), dut_word(),
                        {tbl[i].e_valid, tbl[i].e_data, tbl[i].e_k, tbl[i].e_aligned, tbl[i].e_err});
        end

        // in_valid toggling while aligned: each word appears once, one cycle later.
        $display("[TB] in_valid toggle");
        for (int i = 0; i < 4; i++) begin
            step("toggle_hi", 1'b1, 1'b1, rep(8'h20 + 8'(i)), 4'h0);
            step("toggle_lo", 1'b1, 1'b0, '0, '0);
            checkOutput("toggle_word", {31'b0, out_valid, out_data}, {31'b0, 1'b1, rep(8'h20 + 8'(i))});
        end

        // Lane 2 three symbols late.
        $display("[TB] skew lane2=3");
        step("reset", 1'b0, 1'b0, '0, '0);
        clear_track();
        run_skewed("skew3", 0, 0, 3, 0, 40, 0, 999, 8'h00);
        checkOutput("skew3_aligned", {38'b0, aligned}, 39'd1);
        checkOutput("skew3_no_err", 39'(err_seen), 39'd0);

        // Lane 1 eight symbols late overflows the waiting lanes.
        $display("[TB] skew lane1=8 overflow");
        step("reset", 1'b0, 1'b0, '0, '0);
        clear_track();
        run_skewed("skew8", 0, 8, 0, 0, 30, 0, 999, 8'h00);
        checkOutput("skew8_err_seen", {38'b0, err_seen > 0}, 39'd1);
        checkOutput("skew8_single_pulse", 39'(err_consec), 39'd0);
        checkOutput("skew8_never_aligned", 39'(aligned_seen), 39'd0);
        clear_track();
        run_skewed("skew2_recover", 0, 2, 0, 0, 40, 0, 999, 8'h40);
        checkOutput("skew2_aligned", {38'b0, aligned}, 39'd1);

        // Reset pulse in the middle of a search with data buffered.
        $display("[TB] reset mid-search");
        run_skewed("partial", 0, 3, 0, 0, 2, 0, 999, 8'h00);
        step("mid_reset", 1'b0, 1'b0, '0, '0);
        checkOutput("mid_reset_zero", dut_word(), 39'd0);
        run_skewed("post_reset", 0, 0, 0, 0, 6, 0, 999, 8'h00);
        checkOutput("post_reset_aligned", {38'b0, aligned}, 39'd1);

        // Randomised skews, gaps and stray COM injections.
        $display("[TB] random runs");
        for (int r = 0; r < 8; r++) begin
            run_skewed("random", int'($urandom_range(6)), int'($urandom_range(6)),
                       int'($urandom_range(6)), int'($urandom_range(6)),
                       48, 25, int'($urandom_range(70)), 8'($urandom_range(255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
